// File: rtl/unsigned_mul_8x8_pkg.sv
// Shared widths, FSM state type and array payload for the 8x8 approximate
// multiplier's half-adder reduction stage.
package unsigned_mul_8x8_pkg;

  localparam int unsigned HA_B_W     = 7;
  localparam int unsigned HA_T_W     = 9;
  localparam int unsigned HA_VAL_W   = 10;
  localparam int unsigned PROD_W     = 16;
  localparam int unsigned NUM_ARRAYS = 4;
  localparam int unsigned IDX_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One half-adder array: carry row b above sum row t.
  typedef struct packed {
    logic [HA_B_W-1:0] b;
    logic [HA_T_W-1:0] t;
  } ha_bundle_t;

endpackage

// File: rtl/unsigned_mul_8x8_ha_reduce_ha_array_value.sv
// Value of one half-adder array: sum row plus carry row weighted by 4.
module ha_array_value
  import unsigned_mul_8x8_pkg::*;
(
  input  logic [HA_B_W-1:0]   b,
  input  logic [HA_T_W-1:0]   t,
  output logic [HA_VAL_W-1:0] val_c
);

  assign val_c = HA_VAL_W'(t) + (HA_VAL_W'(b) << 2);

endmodule

// File: rtl/unsigned_mul_8x8_ha_reduce.sv
// Sequential reducer: accumulates the four weighted half-adder arrays, one
// per cycle, into a 16-bit product delivered over a valid/ready handshake.
module unsigned_mul_8x8_ha_reduce
  import unsigned_mul_8x8_pkg::HA_B_W;
  import unsigned_mul_8x8_pkg::HA_T_W;
  import unsigned_mul_8x8_pkg::HA_VAL_W;
  import unsigned_mul_8x8_pkg::PROD_W;
  import unsigned_mul_8x8_pkg::IDX_W;
  import unsigned_mul_8x8_pkg::state_e;
  import unsigned_mul_8x8_pkg::ST_IDLE;
  import unsigned_mul_8x8_pkg::ST_ACC;
  import unsigned_mul_8x8_pkg::ST_DONE;
  import unsigned_mul_8x8_pkg::ha_bundle_t;
#(
  parameter int unsigned NUM_ARRAYS = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [HA_B_W-1:0] ha_array_0_b,
  input  logic [HA_B_W-1:0] ha_array_1_b,
  input  logic [HA_B_W-1:0] ha_array_2_b,
  input  logic [HA_B_W-1:0] ha_array_3_b,
  input  logic [HA_T_W-1:0] ha_array_0_t,
  input  logic [HA_T_W-1:0] ha_array_1_t,
  input  logic [HA_T_W-1:0] ha_array_2_t,
  input  logic [HA_T_W-1:0] ha_array_3_t,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_product,
  output logic [TAG_W-1:0]  out_tag
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ARRAYS - 1);

  state_e               state_q, state_d;
  logic [PROD_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  ha_bundle_t [3:0]     cap_q, cap_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic                 out_valid_q, out_valid_d;
  logic [PROD_W-1:0]    out_product_q, out_product_d;
  logic [TAG_W-1:0]     out_tag_q, out_tag_d;

  ha_bundle_t [3:0]     in_bus_c;
  ha_bundle_t           sel_c;
  logic [HA_VAL_W-1:0]  val_c;
  logic [PROD_W-1:0]    term_c;
  logic                 accept_c;

  assign in_bus_c[0] = {ha_array_0_b, ha_array_0_t};
  assign in_bus_c[1] = {ha_array_1_b, ha_array_1_t};
  assign in_bus_c[2] = {ha_array_2_b, ha_array_2_t};
  assign in_bus_c[3] = {ha_array_3_b, ha_array_3_t};

  // Only the array addressed by idx is weighted this cycle.
  assign sel_c = cap_q[idx_q];

  ha_array_value u_ha_array_value (
    .b     (sel_c.b),
    .t     (sel_c.t),
    .val_c (val_c)
  );

  assign term_c   = PROD_W'(val_c) << {idx_q, 1'b0};
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept_c = in_valid && in_ready;

  // Next-state and datapath control.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    cap_d         = cap_q;
    tag_d         = tag_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    out_tag_d     = out_tag_q;

    if (accept_c) begin
      cap_d       = in_bus_c;
      tag_d       = in_tag;
      acc_d       = '0;
      idx_d       = '0;
      out_valid_d = 1'b0;
      state_d     = ST_ACC;
    end else begin
      case (state_q)
        ST_ACC: begin
          acc_d = acc_q + term_c;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d       = ST_DONE;
            out_valid_d   = 1'b1;
            out_product_d = acc_q + term_c;
            out_tag_d     = tag_q;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      acc_q         <= '0;
      idx_q         <= '0;
      cap_q         <= '0;
      tag_q         <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_tag_q     <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      cap_q         <= cap_d;
      tag_q         <= tag_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      out_tag_q     <= out_tag_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_reduce.sv
// Scoreboard bench for the half-adder reduction stage: driver pushes expected
// products from an arithmetic model, an independent monitor pops and compares.
module tb_unsigned_mul_8x8_ha_reduce;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic [27:0]      in_bb;
  logic [35:0]      in_tt;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_product;
  logic [TAG_W-1:0] out_tag;

  typedef struct packed {
    logic [15:0]      prod;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  int   last_hs_cyc = -1;
  int   last_acc_cyc = -2;

  logic             prev_v = 1'b0;
  logic             prev_r = 1'b0;
  logic [15:0]      prev_p = '0;
  logic [TAG_W-1:0] prev_t = '0;

  unsigned_mul_8x8_ha_reduce #(.NUM_ARRAYS(4), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_tag       (in_tag),
    .ha_array_0_b (in_bb[6:0]),
    .ha_array_1_b (in_bb[13:7]),
    .ha_array_2_b (in_bb[20:14]),
    .ha_array_3_b (in_bb[27:21]),
    .ha_array_0_t (in_tt[8:0]),
    .ha_array_1_t (in_tt[17:9]),
    .ha_array_2_t (in_tt[26:18]),
    .ha_array_3_t (in_tt[35:27]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_product  (out_product),
    .out_tag      (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Product = sum of (t_i + 4*b_i) * 4^i, modulo 2^16.
  function automatic logic [15:0] ref_prod(input logic [27:0] bb, input logic [35:0] tt);
    int unsigned s = 0;
    for (int i = 0; i < 4; i++) begin
      int unsigned t_i = 32'(tt[i*9 +: 9]);
      int unsigned b_i = 32'(bb[i*7 +: 7]);
      s += (t_i + 4 * b_i) * (32'd1 << (2 * i));
    end
    return 16'(s % 32'd65536);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  task automatic send_op(input logic [27:0] bb, input logic [35:0] tt, input logic [TAG_W-1:0] tag);
    int w = 0;
    @(negedge clk);
    in_bb    = bb;
    in_tt    = tt;
    in_tag   = tag;
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 60) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({ref_prod(bb, tt), tag});
      #1;
      acc_cyc_q.push_back(cyc);
      last_acc_cyc = cyc;
      in_valid = 1'b0;
      in_bb    = 28'($urandom());
      in_tt    = 36'({$urandom(), $urandom()});
      in_tag   = TAG_W'($urandom());
    end
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic wait_valid();
    int w = 0;
    @(negedge clk);
    #1;
    while (!out_valid && w < 30) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!out_valid) fail_now("valid_timeout");
  endtask

  task automatic pulse_reset_and_idle();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_acc", 32'(dut.acc_q), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'd0);
    exp_q.delete();
    acc_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Monitor: drives out_ready, checks latency, hold-stability and results.
  initial begin
    exp_t e;
    int   a;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (!rst_n) begin
        prev_v = 1'b0;
        prev_r = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          if (acc_cyc_q.size() == 0) fail_now("stale_out_valid");
          else begin
            a = acc_cyc_q.pop_front();
            check("latency", 32'(cyc + 1 - a), 32'd5);
          end
        end
        if (out_valid && prev_v && !prev_r) begin
          check("hold_product", 32'(out_product), 32'(prev_p));
          check("hold_tag", 32'(out_tag), 32'(prev_t));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_result");
          else begin
            e = exp_q.pop_front();
            check("product", 32'(out_product), 32'(e.prod));
            check("tag", 32'(out_tag), 32'(e.tag));
          end
          last_hs_cyc = cyc + 1;
        end
        prev_v = out_valid;
        prev_r = out_ready;
        prev_p = out_product;
        prev_t = out_tag;
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bb    = '0;
    in_tt    = '0;
    in_tag   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_product", 32'(out_product), 32'd0);
    check("reset_out_tag", 32'(out_tag), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed patterns with out_ready held high.
    ready_mode = 0;
    send_op(28'd0, 36'd0, 4'h5);
    wait_drain();
    send_op(28'd0, 36'h003, 4'h1);
    wait_drain();
    send_op(28'd1 << 14, 36'd1 << 9, 4'h2);
    wait_drain();
    send_op(28'h7F << 21, 36'h1FF << 27, 4'h3);
    wait_drain();
    send_op(28'hFFF_FFFF, 36'hF_FFFF_FFFF, 4'hF);
    wait_drain();

    // Backpressure for 10 cycles, then release with a new op waiting.
    ready_mode = 1;
    send_op(28'($urandom()), 36'({$urandom(), $urandom()}), 4'h9);
    wait_valid();
    repeat (10) begin
      @(negedge clk);
      #1;
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    ready_mode = 0;
    send_op(28'($urandom()), 36'({$urandom(), $urandom()}), 4'hA);
    check("b2b_same_cycle", 32'(last_acc_cyc), 32'(last_hs_cyc));
    wait_drain();

    // Reset while accumulating (idx = 2).
    send_op(28'($urandom()), 36'({$urandom(), $urandom()}), 4'h6);
    @(posedge clk);
    @(posedge clk);
    #2;
    pulse_reset_and_idle();

    // Reset while holding a result.
    ready_mode = 1;
    send_op(28'($urandom()), 36'({$urandom(), $urandom()}), 4'h7);
    wait_valid();
    #2;
    pulse_reset_and_idle();

    // Random traffic with random backpressure.
    ready_mode = 2;
    repeat (40) begin
      send_op(28'($urandom()), 36'({$urandom(), $urandom()}), TAG_W'($urandom()));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
